musb_timer_slave: RTL

Memory-mapped timer/compare peripheral acting as a responder on the core's data-port bus. Decodes single-word requests from the initiator (address, enable, byte write strobes), answers with a one-cycle `ready` or `error` pulse after a programmable number of wait states, and raises a level interrupt on counter/compare match. Sits beside the data memory behind the data-port address decode. Its `irq` output drives one bit of the core's `interrupts` vector.

---
 rtl/musb_timer_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/musb_timer_slave.sv
// rtl/musb_timer_slave.sv - timer/compare responder on the core data-port bus
// Single-word bus slave with wait states, prescaled counter, compare match and level irq.
module musb_timer_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          WAIT_CYCLES = 0,
   parameter int          PRESCALE    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        enable,
   input  logic [3:0]  wr,
   output logic        ready,
   output logic        error,
   output logic        irq
);
   localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST  = PW'(PRESCALE - 1);
   localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    wait_q, wait_d;
   logic [29:0]   addr_q, addr_d;
   logic [3:0]    wr_q, wr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    ctrl_q, ctrl_d;
   logic [31:0]   count_q, count_d;
   logic [31:0]   compare_q, compare_d;
   logic          match_q, match_d;
   logic          irq_q, irq_d;
   logic          ready_q, ready_d;
   logic          error_q, error_d;
   logic [31:0]   data_q, data_d;
   logic [PW-1:0] psc_q, psc_d;

   logic [29:0]   req_addr;
   logic [3:0]    req_wr;
   logic [31:0]   req_data;
   logic          commit, hit, run, tick, match_set, count_wr, w1c;
   logic [31:0]   rd_val;
   logic          unused_addr;

   assign unused_addr = ^address[1:0];

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // commit marks the edge entering RESP; with no wait states the request is still on the bus
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               addr_d  = address[31:2];
               wr_d    = wr;
               wdata_d = data_i;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  wait_d  = WAIT_LOAD;
               end else begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (wait_q == 4'd0) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_addr = (state_q == S_IDLE) ? address[31:2] : addr_q;
      req_wr   = (state_q == S_IDLE) ? wr : wr_q;
      req_data = (state_q == S_IDLE) ? data_i : wdata_q;
      hit      = (req_addr[29:2] == BASE_ADDR[31:4]);
      case (req_addr[1:0])
         2'd0:    rd_val = {29'd0, ctrl_q};
         2'd1:    rd_val = count_q;
         2'd2:    rd_val = compare_q;
         default: rd_val = {31'd0, match_q};
      endcase
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      compare_d = compare_q;
      count_wr  = 1'b0;
      w1c       = 1'b0;
      if (commit && hit) begin
         case (req_addr[1:0])
            2'd0: if (req_wr[0]) ctrl_d = req_data[2:0];
            2'd1: count_wr = |req_wr;
            2'd2: compare_d = merge(compare_q, req_data, req_wr);
            default: w1c = req_wr[0] & req_data[0];
         endcase
      end

      // clearing EN on this edge suppresses the tick immediately
      run       = ctrl_q[0] & ctrl_d[0];
      tick      = run && (psc_q == PSC_LAST);
      psc_d     = (!run || tick) ? '0 : psc_q + 1'b1;
      match_set = tick && (count_q == compare_q);

      if (count_wr)  count_d = merge(count_q, req_data, req_wr);
      else if (tick) count_d = (match_set && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
      else           count_d = count_q;

      match_d = match_set | (match_q & ~w1c);
      irq_d   = match_q & ctrl_q[1];
      ready_d = commit & hit;
      error_d = commit & ~hit;
      data_d  = (commit && hit && req_wr == 4'd0) ? rd_val : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wait_q    <= 4'd0;
         addr_q    <= 30'd0;
         wr_q      <= 4'd0;
         wdata_q   <= 32'd0;
         ctrl_q    <= 3'd0;
         count_q   <= 32'd0;
         compare_q <= 32'hFFFF_FFFF;
         match_q   <= 1'b0;
         irq_q     <= 1'b0;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         data_q    <= 32'd0;
         psc_q     <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         match_q   <= match_d;
         irq_q     <= irq_d;
         ready_q   <= ready_d;
         error_q   <= error_d;
         data_q    <= data_d;
         psc_q     <= psc_d;
      end
   end

   assign data_o = data_q;
   assign ready  = ready_q;
   assign error  = error_q;
   assign irq    = irq_q;
endmodule
